// File: rtl/axonerve_kvs_counter_bank_if.sv
// Bus bundle for axonerve_kvs_counter_bank: per-channel strobes/data in, registered counts and flags out.
interface axonerve_kvs_counter_bank_if #(
    parameter int unsigned C_WIDTH      = 8,
    parameter int unsigned C_CHANNELS   = 4,
    parameter int unsigned C_STEP_WIDTH = 4
);
    localparam int unsigned W = C_WIDTH;
    localparam int unsigned N = C_CHANNELS;
    localparam int unsigned S = C_STEP_WIDTH;

    logic           clken;
    logic [N-1:0]   load;
    logic [N-1:0]   incr;
    logic [N-1:0]   decr;
    logic [N*S-1:0] step;
    logic [N*W-1:0] load_value;
    logic [W-1:0]   thresh;
    logic           clr_err;
    logic [N*W-1:0] count;
    logic [N-1:0]   is_zero;
    logic [N-1:0]   is_max;
    logic [N-1:0]   at_thresh;
    logic [N-1:0]   err;
    logic           all_zero;

    modport master (
        output clken, load, incr, decr, step, load_value, thresh, clr_err,
        input  count, is_zero, is_max, at_thresh, err, all_zero
    );

    modport slave (
        input  clken, load, incr, decr, step, load_value, thresh, clr_err,
        output count, is_zero, is_max, at_thresh, err, all_zero
    );
endinterface

// File: rtl/axonerve_kvs_counter_bank.sv
// Bank of independent up/down counters with load, variable step and registered zero/max/threshold/error flags.
// Optional build macro AXONERVE_KVS_COUNTER_SAT_EN selects saturating instead of wrap-around arithmetic.
module axonerve_kvs_counter_bank #(
    parameter int unsigned       C_WIDTH      = 8,
    parameter int unsigned       C_CHANNELS   = 4,
    parameter int unsigned       C_STEP_WIDTH = 4,
    parameter logic [C_WIDTH-1:0] C_INIT      = '0
) (
    input logic clk,
    input logic rst,
    axonerve_kvs_counter_bank_if.slave bus
);
    localparam int unsigned W   = C_WIDTH;
    localparam int unsigned N   = C_CHANNELS;
    localparam int unsigned S   = C_STEP_WIDTH;
    localparam int unsigned WP1 = W + 1;

    logic [N-1:0] zero_vec;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [W-1:0] cnt_q;
        logic [W-1:0] cnt_d;
        logic [W-1:0] ldv;
        logic [S-1:0] stp;
        logic [W:0]   sum;
        logic [W:0]   diff;
        logic         ovf;
        logic         zero_q;
        logic         max_q;
        logic         thr_q;
        logic         err_q;

        assign stp = bus.step[i*S +: S];
        assign ldv = bus.load_value[i*W +: W];

        // Next count: load wins, then exactly one of incr/decr; both or neither holds.
        always_comb begin
            sum   = {1'b0, cnt_q} + WP1'(stp);
            diff  = {1'b0, cnt_q} - WP1'(stp);
            cnt_d = cnt_q;
            ovf   = 1'b0;
            if (bus.load[i]) begin
                cnt_d = ldv;
            end else if (bus.incr[i] && !bus.decr[i]) begin
                ovf = sum[W];
`ifdef AXONERVE_KVS_COUNTER_SAT_EN
                cnt_d = sum[W] ? '1 : sum[W-1:0];
`else
                cnt_d = sum[W-1:0];
`endif
            end else if (bus.decr[i] && !bus.incr[i]) begin
                ovf = diff[W];
`ifdef AXONERVE_KVS_COUNTER_SAT_EN
                cnt_d = diff[W] ? '0 : diff[W-1:0];
`else
                cnt_d = diff[W-1:0];
`endif
            end
        end

        // Flags are derived from the next count so they always match the registered count.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q  <= C_INIT;
                zero_q <= (C_INIT == '0);
                max_q  <= (C_INIT == '1);
                thr_q  <= 1'b0;
                err_q  <= 1'b0;
            end else if (bus.clken) begin
                cnt_q  <= cnt_d;
                zero_q <= (cnt_d == '0);
                max_q  <= (cnt_d == '1);
                thr_q  <= (cnt_d >= bus.thresh);
                err_q  <= ovf | (err_q & ~bus.clr_err);
            end
        end

        assign bus.count[i*W +: W] = cnt_q;
        assign bus.is_zero[i]      = zero_q;
        assign bus.is_max[i]       = max_q;
        assign bus.at_thresh[i]    = thr_q;
        assign bus.err[i]          = err_q;
        assign zero_vec[i]         = zero_q;
    end

    assign bus.all_zero = &zero_vec;
endmodule

// File: tb/tb_axonerve_kvs_counter_bank.sv
// Directed scoreboard bench for axonerve_kvs_counter_bank (W=8, N=4, S=4, C_INIT=0), both arithmetic builds.
module tb_axonerve_kvs_counter_bank;
    localparam int unsigned W = 8;
    localparam int unsigned N = 4;
    localparam int unsigned S = 4;

    typedef enum int {
        SEL_COUNT, SEL_ZERO, SEL_MAX, SEL_THR, SEL_ERR, SEL_ALLZ
    } sel_t;

    typedef struct {
        string       tag;
        sel_t        sel;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];

    axonerve_kvs_counter_bank_if #(.C_WIDTH(W), .C_CHANNELS(N), .C_STEP_WIDTH(S)) bus ();

    axonerve_kvs_counter_bank #(
        .C_WIDTH(W), .C_CHANNELS(N), .C_STEP_WIDTH(S), .C_INIT(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(sel_t sel);
        case (sel)
            SEL_COUNT: return bus.count;
            SEL_ZERO:  return 32'(bus.is_zero);
            SEL_MAX:   return 32'(bus.is_max);
            SEL_THR:   return 32'(bus.at_thresh);
            SEL_ERR:   return 32'(bus.err);
            default:   return 32'(bus.all_zero);
        endcase
    endfunction

    task automatic push(input string tag, input sel_t sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.load       = '0;
        bus.incr       = '0;
        bus.decr       = '0;
        bus.step       = '0;
        bus.load_value = '0;
        bus.clr_err    = 1'b0;
        bus.clken      = 1'b1;
    endtask

    // Apply the driven inputs for one edge, then compare everything queued for that edge.
    task automatic tick();
        exp_t        e;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_cmp++;
            assert (obs === e.exp)
            else begin
                n_bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle_inputs();
        bus.thresh = 8'hFF;

        // Reset for two cycles.
        tick();
        push("rst_count", SEL_COUNT, 32'h0000_0000);
        push("rst_zero",  SEL_ZERO,  32'hF);
        push("rst_max",   SEL_MAX,   32'h0);
        push("rst_thr",   SEL_THR,   32'h0);
        push("rst_err",   SEL_ERR,   32'h0);
        push("rst_allz",  SEL_ALLZ,  32'h1);
        tick();

        // First strobe after reset.
        rst = 1'b0;
        bus.incr[0] = 1'b1;
        bus.step[0 +: 4] = 4'd3;
        push("inc0_count", SEL_COUNT, 32'h0000_0003);
        push("inc0_zero",  SEL_ZERO,  32'hE);
        push("inc0_allz",  SEL_ALLZ,  32'h0);
        tick();

        // Overflow on ch1.
        idle_inputs();
        bus.load[1] = 1'b1;
        bus.load_value[8 +: 8] = 8'd250;
        push("ld1_count", SEL_COUNT, 32'h0000_FA03);
        tick();
        idle_inputs();
        bus.incr[1] = 1'b1;
        bus.step[4 +: 4] = 4'd9;
`ifdef AXONERVE_KVS_COUNTER_SAT_EN
        push("ovf1_count", SEL_COUNT, 32'h0000_FF03);
        push("ovf1_max",   SEL_MAX,   32'h2);
`else
        push("ovf1_count", SEL_COUNT, 32'h0000_0303);
        push("ovf1_max",   SEL_MAX,   32'h0);
`endif
        push("ovf1_err",  SEL_ERR,  32'h2);
        push("ovf1_zero", SEL_ZERO, 32'hC);
        tick();

        // Underflow on ch2.
        idle_inputs();
        bus.load[2] = 1'b1;
        bus.load_value[16 +: 8] = 8'd2;
        push("ld2_zero", SEL_ZERO, 32'h8);
        tick();
        idle_inputs();
        bus.decr[2] = 1'b1;
        bus.step[8 +: 4] = 4'd5;
`ifdef AXONERVE_KVS_COUNTER_SAT_EN
        push("unf2_count", SEL_COUNT, 32'h0000_FF03);
        push("unf2_zero",  SEL_ZERO,  32'hC);
`else
        push("unf2_count", SEL_COUNT, 32'h00FD_0303);
        push("unf2_zero",  SEL_ZERO,  32'h8);
`endif
        push("unf2_err", SEL_ERR, 32'h6);
        tick();

        // Priority on ch3: load beats incr/decr, then incr+decr holds.
        idle_inputs();
        bus.load[3] = 1'b1;
        bus.incr[3] = 1'b1;
        bus.decr[3] = 1'b1;
        bus.step[12 +: 4] = 4'd4;
        bus.load_value[24 +: 8] = 8'd7;
`ifdef AXONERVE_KVS_COUNTER_SAT_EN
        push("pri_ld_count", SEL_COUNT, 32'h0700_FF03);
`else
        push("pri_ld_count", SEL_COUNT, 32'h07FD_0303);
`endif
        tick();
        idle_inputs();
        bus.incr[3] = 1'b1;
        bus.decr[3] = 1'b1;
        bus.step[12 +: 4] = 4'd4;
`ifdef AXONERVE_KVS_COUNTER_SAT_EN
        push("pri_hold_count", SEL_COUNT, 32'h0700_FF03);
`else
        push("pri_hold_count", SEL_COUNT, 32'h07FD_0303);
`endif
        push("pri_hold_err", SEL_ERR, 32'h6);
        tick();

        // Threshold crossing and threshold change on a hold cycle.
        idle_inputs();
        bus.thresh = 8'd10;
        bus.load[0] = 1'b1;
        bus.load_value[0 +: 8] = 8'd9;
`ifdef AXONERVE_KVS_COUNTER_SAT_EN
        push("thr_below", SEL_THR, 32'h2);
`else
        push("thr_below", SEL_THR, 32'h4);
`endif
        tick();
        idle_inputs();
        bus.incr[0] = 1'b1;
        bus.step[0 +: 4] = 4'd1;
`ifdef AXONERVE_KVS_COUNTER_SAT_EN
        push("thr_reach", SEL_THR, 32'h3);
`else
        push("thr_reach", SEL_THR, 32'h5);
`endif
        tick();
        idle_inputs();
        bus.thresh = 8'd11;
`ifdef AXONERVE_KVS_COUNTER_SAT_EN
        push("thr_raise", SEL_THR, 32'h2);
        push("thr_count", SEL_COUNT, 32'h0700_FF0A);
`else
        push("thr_raise", SEL_THR, 32'h4);
        push("thr_count", SEL_COUNT, 32'h07FD_030A);
`endif
        tick();

        // clken low freezes everything, including clr_err.
        idle_inputs();
        bus.clken = 1'b0;
        bus.incr  = 4'hF;
        bus.step  = 16'h1111;
        bus.clr_err = 1'b1;
`ifdef AXONERVE_KVS_COUNTER_SAT_EN
        push("hold_count", SEL_COUNT, 32'h0700_FF0A);
        push("hold_zero",  SEL_ZERO,  32'h4);
        push("hold_thr",   SEL_THR,   32'h2);
`else
        push("hold_count", SEL_COUNT, 32'h07FD_030A);
        push("hold_zero",  SEL_ZERO,  32'h0);
        push("hold_thr",   SEL_THR,   32'h4);
`endif
        push("hold_err", SEL_ERR, 32'h6);
        tick();

        // clr_err with a simultaneous new error on ch1.
        idle_inputs();
        bus.load[1] = 1'b1;
        bus.load_value[8 +: 8] = 8'd255;
        push("ld1_max", SEL_MAX, 32'h2);
        tick();
        idle_inputs();
        bus.incr[1] = 1'b1;
        bus.step[4 +: 4] = 4'd1;
        bus.clr_err = 1'b1;
`ifdef AXONERVE_KVS_COUNTER_SAT_EN
        push("clr_count", SEL_COUNT, 32'h0700_FF0A);
`else
        push("clr_count", SEL_COUNT, 32'h07FD_000A);
`endif
        push("clr_err", SEL_ERR, 32'h2);
        tick();

        // Mid-operation reset overrides strobes; first strobe after release is honoured.
        idle_inputs();
        rst = 1'b1;
        bus.incr = 4'hF;
        bus.step = 16'h1111;
        push("rst2_count", SEL_COUNT, 32'h0000_0000);
        push("rst2_err",   SEL_ERR,   32'h0);
        push("rst2_allz",  SEL_ALLZ,  32'h1);
        tick();
        idle_inputs();
        rst = 1'b0;
        bus.incr = 4'h3;
        bus.step[0 +: 4] = 4'd2;
        push("post_count", SEL_COUNT, 32'h0000_0002);
        push("post_zero",  SEL_ZERO,  32'hE);
        push("post_err",   SEL_ERR,   32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axonerve_kvs_counter_bank.md
# axonerve_kvs_counter_bank

Parametrised bank of independent up/down counters with variable step, load, and per-channel registered status flags. Serves the KVS kernel control path: outstanding-request, credit and burst-remaining tracking, where several channels need concurrent counts plus zero, max and threshold indications. Every flag is registered and aligned with the count it describes, so consumers see no combinational path from increment/decrement inputs.

## Interface
Parameters:
- C_WIDTH, 8: counter width W per channel, ≥2.
- C_CHANNELS, 4: number of channels N, ≥1.
- C_STEP_WIDTH, 4: step field width S, 1 ≤ S ≤ W.
- C_INIT, {W{1'b0}}: reset value, applied to every channel.

Ports (channel i occupies bits [i*W +: W], [i*S +: S] or bit [i]):
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clken  in  1  global enable; when low, all state holds.
- load  in  N  per-channel load strobe.
- incr  in  N  per-channel increment strobe.
- decr  in  N  per-channel decrement strobe.
- step  in  N*S  per-channel unsigned step magnitude.
- load_value  in  N*W  per-channel load data.
- thresh  in  W  shared unsigned threshold.
- clr_err  in  1  clears every err bit.
- count  out  N*W  registered counts.
- is_zero  out  N  count == 0.
- is_max  out  N  count == 2^W−1.
- at_thresh  out  N  count ≥ thresh.
- err  out  N  sticky overflow/underflow event.
- all_zero  out  1  AND of is_zero (combinational from registers).

## Operation
- Per-channel priority, evaluated when clken=1: rst > load > (incr XOR decr) > hold.
- load: next = load_value; step, incr and decr are ignored.
- incr & ~decr: sum = {1'b0,count} + zero-extended step, computed in W+1 bits; carry = sum[W].
- ~incr & decr: diff = {1'b0,count} − step, computed in W+1 bits; borrow = diff[W].
- incr & decr, or neither: hold. step = 0 also holds, but is still an active operation and cannot raise err.
- On carry or borrow, result depends on configuration (see below). err[i] is set whenever the result is not the exact arithmetic value.
- Flags are computed from the next count and registered with it. Consequence: is_zero, is_max and at_thresh always describe the count currently on the output.
- at_thresh compares next count against the thresh value sampled in the same cycle. It is recomputed on every clken cycle, including hold cycles, so a thresh change is reflected one cycle later.
- err is sticky. clr_err clears it on a clken cycle. If a new error occurs in the same cycle as clr_err, err is set. load does not affect err.
- clken=0: every register, including flags and err, holds; clr_err is ignored.
- Channels are fully independent; no cross-channel arbitration.

## Timing
- Latency: 1 cycle from a sampled strobe to updated count and flags.
- Reset values:
  - count = C_INIT.
  - is_zero = (C_INIT == 0).
  - is_max = (C_INIT == 2^W−1).
  - at_thresh = 0.
  - err = 0.
- rst asserted mid-operation overrides all strobes that cycle; the first strobe after reset is honoured on the first cycle with rst=0.
- Back-to-back strobes on consecutive cycles are each applied; full throughput is one operation per channel per cycle.
- No handshake; strobes are single-cycle qualified by clken.

## Configuration
- AXONERVE_KVS_COUNTER_SAT_EN defined: saturating arithmetic. A carry clamps the count to 2^W−1 and a borrow clamps it to 0; err is set in both cases.
- Not defined: modulo-2^W wrap-around. count = sum[W-1:0] or diff[W-1:0]; err is set on carry or borrow.
- Flag logic and all other behaviour are identical in both builds.

## Test plan
Configuration for all scenarios: W=8, N=4, S=4, C_INIT=0.
- Reset/flags:
  - Stimulus: assert rst for 2 cycles.
  - Required: count=0, is_zero=4'hF, is_max=0, err=0, all_zero=1.
  - Stimulus: then incr[0] with step[0]=3.
  - Required: one cycle later count[0]=3, is_zero[0]=0, all_zero=0.
- Wrap vs saturate:
  - Stimulus: load ch1=250, then incr with step=9.
  - Required without macro: count=3, err[1]=1.
  - Required with macro: count=255, is_max[1]=1, err[1]=1.
- Underflow:
  - Stimulus: load ch2=2, then decr with step=5.
  - Required without macro: count=253.
  - Required with macro: count=0, is_zero[2]=1.
  - Required in both builds: err[2]=1.
- Priority:
  - Stimulus: load+incr+decr same cycle on ch3 with load_value=7.
  - Required: count=7.
  - Stimulus: then incr+decr together with step=4.
  - Required: count holds at 7, err unchanged.
- Threshold:
  - Stimulus: thresh=10, ch0 at 9, incr with step=1.
  - Required: at_thresh[0]=1 next cycle.
  - Stimulus: then hold with thresh=11.
  - Required: at_thresh[0]=0 one cycle later.
- clken/clr_err:
  - Stimulus: clken=0 with incr on all channels and clr_err=1.
  - Required: no change to any output.
  - Stimulus: clken=1 with clr_err=1 and a simultaneous wrap on ch1.
  - Required: err=4'b0010.
